// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART Sender between NUM_REQ byte producers. Requesters are
//   served round-robin. Each grant latches the winner's byte onto TX_DATA and
//   pulses req_ready. The next cycle pulses TX_EN. The arbiter then follows
//   TX_STATUS through busy and back to idle before it grants again.
//   Every output is registered.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  WAIT_ACK watchdog length (>= 1); used with the macro only
//
// Optional feature
//   `define UART_ARB_TIMEOUT_EN builds the WAIT_ACK watchdog. The watchdog
//   drives err_timeout and returns the FSM to IDLE. Without the macro,
//   err_timeout is tied to 0.
//
// Ports
//   sysclk       in   clock shared with the Sender
//   reset        in   synchronous, active-high
//   req_valid    in   [NUM_REQ]    per-requester byte pending
//   req_data     in   [8*NUM_REQ]  requester i byte in [8i+7:8i]
//   req_ready    out  [NUM_REQ]    one-hot, one-cycle grant pulse
//   TX_STATUS    in   Sender status: 1 = idle, 0 = transmitting
//   TX_DATA      out  [8]  byte handed to the Sender, held until next grant
//   TX_EN        out  one-cycle launch pulse
//   grant_id     out  [3]  index of the last granted requester
//   busy         out  1 whenever the FSM is not in IDLE
//   err_timeout  out  one-cycle watchdog pulse
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 TX_STATUS,
  output logic [7:0]           TX_DATA,
  output logic                 TX_EN,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err_timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [2:0]           ptr;
  logic [2:0]           ptr_nxt;
  logic [7:0]           tx_data_nxt;
  logic [NUM_REQ-1:0]   req_ready_nxt;
  logic [2:0]           grant_id_nxt;
  logic                 tx_en_nxt;

  logic                 found;
  logic [2:0]           winner;
  logic [7:0]           win_data;
  logic [2:0]           ptr_adv;
  logic                 start;
  logic                 timeout_hit;
  int unsigned          idx;

  // Round-robin search: the first valid requester at or after ptr wins,
  // wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && ((req_valid >> idx) & NUM_REQ'(1)) != '0) begin
        found  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(winner) == i) win_data = req_data[8*i +: 8];
    end
  end

  assign ptr_adv = (32'(winner) + 32'd1 >= NUM_REQ) ? '0 : winner + 3'd1;
  assign start   = found && TX_STATUS;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        err_q;

  // The counter is cleared in every other state, so it reads 0 at the first
  // WAIT_ACK edge. The last allowed edge is TIMEOUT_CYCLES after TX_EN rose.
  always_ff @(posedge sysclk) begin
    if (reset || state != WAIT_ACK) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 16'd1;
  end

  assign timeout_hit = (state == WAIT_ACK) && TX_STATUS &&
                       (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sysclk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= timeout_hit;
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      TX_DATA   <= '0;
      req_ready <= '0;
      grant_id  <= '0;
      TX_EN     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      TX_DATA   <= tx_data_nxt;
      req_ready <= req_ready_nxt;
      grant_id  <= grant_id_nxt;
      TX_EN     <= tx_en_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (!TX_STATUS)       state_nxt = WAIT_DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (TX_STATUS) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    tx_data_nxt   = TX_DATA;
    req_ready_nxt = '0;
    grant_id_nxt  = grant_id;
    tx_en_nxt     = 1'b0;
    ptr_nxt       = ptr;
    if (state == IDLE && start) begin
      tx_data_nxt   = win_data;
      req_ready_nxt = NUM_REQ'(1) << winner;
      grant_id_nxt  = winner;
      ptr_nxt       = ptr_adv;
    end
    if (state == LAUNCH) tx_en_nxt = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int FRAME = 10;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        TX_STATUS;
  logic [7:0]  TX_DATA;
  logic        TX_EN;
  logic [2:0]  grant_id;
  logic        busy;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .TX_STATUS(TX_STATUS),
    .TX_DATA(TX_DATA),
    .TX_EN(TX_EN),
    .grant_id(grant_id),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 sysclk = ~sysclk;

  // Sender model: a launch seen at an edge keeps TX_STATUS low for FRAME cycles.
  bit sender_on  = 1'b1;
  bit force_busy = 1'b0;
  int frame_cnt  = 0;
  always @(posedge sysclk) begin
    if (sender_on && TX_EN === 1'b1) frame_cnt <= FRAME;
    else if (frame_cnt > 0)          frame_cnt <= frame_cnt - 1;
  end
  assign TX_STATUS = (frame_cnt == 0) && !force_busy;

  // TX_STATUS as sampled by the DUT at the most recent edge.
  logic status_at_edge = 1'b1;
  always @(posedge sysclk) status_at_edge <= TX_STATUS;

  typedef struct {
    logic [7:0] data;
    logic [2:0] id;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int tx_en_pulses = 0;
  int err_pulses   = 0;

  always @(negedge sysclk) begin
    if (reset === 1'b1) begin
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL ready_in_reset: got %b expected 0000", req_ready);
      end
    end else begin
      if (TX_EN === 1'b1) begin
        tx_en_pulses++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_launch: got TX_DATA=%h with no frame expected", TX_DATA);
        end else begin
          e = sb.pop_front();
          if (TX_DATA !== e.data || grant_id !== e.id) begin
            errors++;
            $display("FAIL launch_data: got data=%h id=%0d expected data=%h id=%0d",
                     TX_DATA, grant_id, e.data, e.id);
          end
        end
      end
      if (req_ready !== 4'b0000) begin
        checks++;
        if (status_at_edge !== 1'b1) begin
          errors++;
          $display("FAIL grant_while_sender_busy: got status=%b expected 1", status_at_edge);
        end
      end
      if (err_timeout === 1'b1) err_pulses++;
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic [2:0] id);
    exp_t x;
    x.data = d;
    x.id   = id;
    sb.push_back(x);
  endtask

  task automatic wait_ready(input string name, output logic [3:0] got);
    int n = 0;
    got = '0;
    while (n < 300) begin
      @(negedge sysclk);
      n++;
      if (req_ready !== 4'b0000) begin
        got = req_ready;
        break;
      end
    end
    if (got == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got no req_ready expected a grant", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge sysclk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: got busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    for (int c = 0; c < 2; c++) begin
      @(negedge sysclk);
      checks++;
      if ({req_ready, TX_EN, busy, err_timeout} !== 7'b0) begin
        errors++;
        $display("FAIL reset_ctrl: got ready=%b en=%b busy=%b err=%b expected all 0",
                 req_ready, TX_EN, busy, err_timeout);
      end
      checks++;
      if (TX_DATA !== 8'h00 || grant_id !== 3'd0) begin
        errors++;
        $display("FAIL reset_data: got data=%h id=%0d expected 00 and 0", TX_DATA, grant_id);
      end
    end
    reset     = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int n      = 0;
    int start  = tx_en_pulses;
    logic [3:0] exp_oh;
    req_data = 32'h13121110;
    for (int g = 0; g < 5; g++) push_exp(8'h10 + 8'(g % 4), 3'(g % 4));
    req_valid = 4'b1111;
    while (grants < 5 && n < 500) begin
      @(negedge sysclk);
      n++;
      if (req_ready !== 4'b0000) begin
        exp_oh = 4'b0001 << (grants % 4);
        checks++;
        if (req_ready !== exp_oh || TX_DATA !== 8'h10 + 8'(grants % 4)) begin
          errors++;
          $display("FAIL rr_grant%0d: got ready=%b data=%h expected ready=%b data=%h",
                   grants, req_ready, TX_DATA, exp_oh, 8'h10 + 8'(grants % 4));
        end
        grants++;
        if (grants == 5) req_valid = 4'b0000;
      end
    end
    checks++;
    if (grants != 5) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d expected 5", grants);
    end
    n = 0;
    while (tx_en_pulses - start < 5 && n < 50) begin
      @(negedge sysclk);
      n++;
    end
    wait_idle("rr");
    checks++;
    if (tx_en_pulses - start != 5) begin
      errors++;
      $display("FAIL rr_launch_count: got %0d expected 5", tx_en_pulses - start);
    end
  endtask

  task automatic test_single();
    req_data  = 32'h00A50000;
    push_exp(8'hA5, 3'd2);
    req_valid = 4'b0100;
    @(negedge sysclk);
    checks++;
    if (req_ready !== 4'b0100 || TX_DATA !== 8'hA5 || busy !== 1'b1 || TX_EN !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got ready=%b data=%h busy=%b en=%b expected 0100 a5 1 0",
               req_ready, TX_DATA, busy, TX_EN);
    end
    req_valid = 4'b0000;
    @(negedge sysclk);
    checks++;
    if (TX_EN !== 1'b1 || req_ready !== 4'b0000 || grant_id !== 3'd2) begin
      errors++;
      $display("FAIL single_launch: got en=%b ready=%b id=%0d expected 1 0000 2",
               TX_EN, req_ready, grant_id);
    end
    @(negedge sysclk);
    checks++;
    if (TX_EN !== 1'b0) begin
      errors++;
      $display("FAIL single_launch_width: got en=%b expected 0", TX_EN);
    end
    wait_idle("single");
  endtask

  task automatic test_busy_at_idle();
    force_busy = 1'b1;
    req_data   = 32'h00000055;
    req_valid  = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge sysclk);
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_idle_hold%0d: got ready=%b busy=%b expected 0000 0", c, req_ready, busy);
      end
    end
    force_busy = 1'b0;
    push_exp(8'h55, 3'd0);
    @(negedge sysclk);
    checks++;
    if (req_ready !== 4'b0001 || TX_DATA !== 8'h55) begin
      errors++;
      $display("FAIL busy_idle_grant: got ready=%b data=%h expected 0001 55", req_ready, TX_DATA);
    end
    req_valid = 4'b0000;
    repeat (2) @(negedge sysclk);
    wait_idle("busy_idle");
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] got;
    int n = 0;
    req_data  = 32'h44772211;
    push_exp(8'h77, 3'd2);
    req_valid = 4'b0100;
    wait_ready("mid", got);
    req_valid = 4'b0000;
    while (TX_STATUS !== 1'b0 && n < 20) begin
      @(negedge sysclk);
      n++;
    end
    repeat (2) @(negedge sysclk);
    checks++;
    if (busy !== 1'b1 || TX_STATUS !== 1'b0) begin
      errors++;
      $display("FAIL mid_in_frame: got busy=%b status=%b expected 1 0", busy, TX_STATUS);
    end
    req_valid = 4'b1111;
    reset     = 1'b1;
    @(negedge sysclk);
    checks++;
    if ({busy, TX_EN, req_ready} !== 6'b0 || TX_DATA !== 8'h00 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_out: got busy=%b en=%b ready=%b data=%h id=%0d expected all 0",
               busy, TX_EN, req_ready, TX_DATA, grant_id);
    end
    reset = 1'b0;
    push_exp(8'h11, 3'd0);
    wait_ready("mid_after", got);
    req_valid = 4'b0000;
    checks++;
    if (got !== 4'b0001) begin
      errors++;
      $display("FAIL mid_restart_ptr: got ready=%b expected 0001", got);
    end
    repeat (2) @(negedge sysclk);
    wait_idle("mid");
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] got;
    sender_on = 1'b0;
    req_data  = 32'h00004D3C;
    push_exp(8'h3C, 3'd0);
    req_valid = 4'b0001;
    wait_ready("to", got);
    req_valid = 4'b0000;
    @(negedge sysclk);
    checks++;
    if (TX_EN !== 1'b1) begin
      errors++;
      $display("FAIL to_launch: got en=%b expected 1", TX_EN);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge sysclk);
      if (c == 1) begin
        sender_on = 1'b1;
        req_valid = 4'b0010;
        push_exp(8'h4D, 3'd1);
      end
      checks++;
      if (err_timeout !== (c == 4)) begin
        errors++;
        $display("FAIL to_err_c%0d: got %b expected %b", c, err_timeout, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL to_back_idle: got busy=%b expected 0", busy);
        end
      end
      if (c == 5) begin
        checks++;
        if (req_ready !== 4'b0010) begin
          errors++;
          $display("FAIL to_next_grant: got ready=%b expected 0010", req_ready);
        end
        req_valid = 4'b0000;
      end
    end
    repeat (2) @(negedge sysclk);
    wait_idle("to");
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL global_watchdog: got no finish expected finish before 300us");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_busy_at_idle();
    test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge sysclk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    checks++;
`ifdef UART_ARB_TIMEOUT_EN
    if (err_pulses != 1) begin
      errors++;
      $display("FAIL err_pulse_total: got %0d expected 1", err_pulses);
    end
`else
    if (err_pulses != 0) begin
      errors++;
      $display("FAIL err_pulse_total: got %0d expected 0", err_pulses);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
